// File: rtl/eth_fifo_pkg.sv
// Shared types and sizing helpers for the store-and-forward Ethernet frame FIFO.
package eth_fifo_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StDrop
  } wr_state_e;

  localparam int unsigned StatusWidth = 4;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/eth_frame_fifo_if.sv
// AXI-Stream style handshake bundle used on both sides of the frame FIFO.
interface eth_frame_fifo_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tuser;
  logic                  tready;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/eth_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port with read enable.
module eth_fifo_ram #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4096,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata <= mem_q[raddr];
  end

endmodule

// File: rtl/eth_frame_fifo.sv
// Store-and-forward frame FIFO: frames become readable only once their last beat commits;
// bad or overflowing frames are rolled back to the commit pointer instead of backpressured.
module eth_frame_fifo
  import eth_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned DEPTH           = 4096,
  parameter bit          DROP_BAD_FRAMES = 1'b1
) (
  input  logic                         aclk,
  input  logic                         reset,
  eth_frame_fifo_if.slave              s_axis,
  eth_frame_fifo_if.master             m_axis,
  output logic                         fifo_overflow,
  output logic                         fifo_bad_frame,
  output logic [StatusWidth-1:0]       fifo_status,
  output logic [ptr_width(DEPTH)-1:0]  frame_count
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned AW = PW - 1;
  localparam int unsigned WW = DATA_WIDTH + 1;
  localparam logic [PW-1:0] PtrOne = PW'(1);

  wr_state_e     state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d, rd_ptr_q, frame_count_q;
  logic [PW-1:0] occ;
  logic          beat, full, ram_we, commit, ovf_d, bad_d, ovf_q, bad_q;
  logic [WW-1:0] ram_rdata, out_q;
  logic          rd_valid_q, out_valid_q, out_ready, fetch, frame_done;

  assign s_axis.tready = ~reset;
  assign beat          = s_axis.tvalid & ~reset;
  assign occ           = wr_ptr_q - rd_ptr_q;
  assign full          = (occ == PW'(DEPTH));

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    ram_we      = 1'b0;
    commit      = 1'b0;
    ovf_d       = 1'b0;
    bad_d       = 1'b0;
    if (beat) begin
      unique case (state_q)
        StIdle, StWrite: begin
          if (full) begin
            wr_ptr_d = wr_commit_q;
            ovf_d    = 1'b1;
            state_d  = s_axis.tlast ? StIdle : StDrop;
          end else if (s_axis.tlast && s_axis.tuser && DROP_BAD_FRAMES) begin
            wr_ptr_d = wr_commit_q;
            bad_d    = 1'b1;
            state_d  = StIdle;
          end else begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PtrOne;
            if (s_axis.tlast) begin
              wr_commit_d = wr_ptr_q + PtrOne;
              commit      = 1'b1;
              state_d     = StIdle;
            end else begin
              state_d = StWrite;
            end
          end
        end
        StDrop: if (s_axis.tlast) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Two-stage read pipeline: RAM output register then output register; a fetch is only
  // issued when the RAM stage is free or draining so its held word is never overwritten.
  assign out_ready  = ~out_valid_q | m_axis.tready;
  assign fetch      = (rd_ptr_q != wr_commit_q) & (~rd_valid_q | out_ready);
  assign frame_done = out_valid_q & m_axis.tready & out_q[DATA_WIDTH];

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q       <= StIdle;
      wr_ptr_q      <= '0;
      wr_commit_q   <= '0;
      rd_ptr_q      <= '0;
      frame_count_q <= '0;
      ovf_q         <= 1'b0;
      bad_q         <= 1'b0;
      rd_valid_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_q         <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      wr_commit_q   <= wr_commit_d;
      frame_count_q <= frame_count_q + PW'(commit) - PW'(frame_done);
      ovf_q         <= ovf_d;
      bad_q         <= bad_d;
      if (fetch) rd_ptr_q <= rd_ptr_q + PtrOne;
      if (fetch) rd_valid_q <= 1'b1;
      else if (out_ready) rd_valid_q <= 1'b0;
      if (out_ready) begin
        out_valid_q <= rd_valid_q;
        if (rd_valid_q) out_q <= ram_rdata;
      end
    end
  end

  eth_fifo_ram #(
    .WIDTH (WW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (aclk),
    .we    (ram_we),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata ({s_axis.tlast, s_axis.tdata}),
    .re    (fetch),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (ram_rdata)
  );

  assign m_axis.tvalid  = out_valid_q;
  assign m_axis.tdata   = out_q[DATA_WIDTH-1:0];
  assign m_axis.tlast   = out_q[DATA_WIDTH];
  assign m_axis.tuser   = 1'b0;
  assign fifo_overflow  = ovf_q;
  assign fifo_bad_frame = bad_q;
  assign frame_count    = frame_count_q;
  // Occupancy never exceeds DEPTH, so the top pointer bit alone marks the saturated case.
  assign fifo_status    = occ[PW-1] ? '1 : StatusWidth'(occ >> (AW - 4));

endmodule

// File: tb/tb_eth_frame_fifo.sv
// Randomised and directed bench for eth_frame_fifo against a frame-level queue model.
module tb_eth_frame_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned PW    = 7;

  logic          aclk = 1'b0;
  logic          reset = 1'b1;
  logic          fifo_overflow, fifo_bad_frame;
  logic [3:0]    fifo_status;
  logic [PW-1:0] frame_count;

  eth_frame_fifo_if #(.DATA_WIDTH(DW)) s_axis ();
  eth_frame_fifo_if #(.DATA_WIDTH(DW)) m_axis ();

  eth_frame_fifo #(
    .DATA_WIDTH      (DW),
    .DEPTH           (DEPTH),
    .DROP_BAD_FRAMES (1'b1)
  ) dut (
    .aclk           (aclk),
    .reset          (reset),
    .s_axis         (s_axis),
    .m_axis         (m_axis),
    .fifo_overflow  (fifo_overflow),
    .fifo_bad_frame (fifo_bad_frame),
    .fifo_status    (fifo_status),
    .frame_count    (frame_count)
  );

  always #5 aclk = ~aclk;

  int         vectors = 0;
  int         miscompares = 0;
  logic [8:0] exp_q[$];
  logic [8:0] part_q[$];
  bit         dropping, exp_ovf, exp_bad, hold_v, chk_en, gap_mon, started, tog;
  logic [8:0] hold_w;
  int         frames, gaps, ovf_seen, bad_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit pick_rdy(input int mode);
    case (mode)
      0: return 1'b0;
      1: return 1'b1;
      2: begin tog = ~tog; return tog; end
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // One clock: check state left by the previous edge, drive inputs, advance the model.
  task automatic step(input bit v, input logic [7:0] d, input bit l, input bit u,
                      input bit rdy, input bit rst);
    int         st;
    logic [8:0] w;
    @(negedge aclk);
    if (chk_en) begin
      check("overflow", 32'(fifo_overflow), 32'(exp_ovf));
      check("bad_frame", 32'(fifo_bad_frame), 32'(exp_bad));
      check("frame_count", 32'(frame_count), frames);
      if (fifo_overflow) ovf_seen++;
      if (fifo_bad_frame) bad_seen++;
      if (reset) begin
        check("rst_tready", 32'(s_axis.tready), 0);
        check("rst_tvalid", 32'(m_axis.tvalid), 0);
        check("rst_tlast", 32'(m_axis.tlast), 0);
        check("rst_tdata", 32'(m_axis.tdata), 0);
      end else begin
        check("tready", 32'(s_axis.tready), 1);
      end
      if (exp_q.size() == 0) begin
        st = part_q.size() * 16 / DEPTH;
        if (st > 15) st = 15;
        check("idle_tvalid", 32'(m_axis.tvalid), 0);
        check("status", 32'(fifo_status), st);
      end
      if (hold_v) begin
        check("stall_valid", 32'(m_axis.tvalid), 1);
        check("stall_word", 32'({m_axis.tlast, m_axis.tdata}), 32'(hold_w));
      end
      if (gap_mon) begin
        if (m_axis.tvalid) started = 1'b1;
        else if (started && exp_q.size() > 0) gaps++;
      end
    end
    reset         = rst;
    s_axis.tvalid = v;
    s_axis.tdata  = d;
    s_axis.tlast  = l;
    s_axis.tuser  = u;
    m_axis.tready = rdy;
    hold_v = 1'b0;
    if (!rst && m_axis.tvalid && exp_q.size() > 0) begin
      if (rdy) begin
        w = exp_q.pop_front();
        check("rd_word", 32'({m_axis.tlast, m_axis.tdata}), 32'(w));
        if (w[8]) frames--;
      end else begin
        hold_v = 1'b1;
        hold_w = {m_axis.tlast, m_axis.tdata};
      end
    end
    exp_ovf = 1'b0;
    exp_bad = 1'b0;
    if (rst) begin
      exp_q.delete();
      part_q.delete();
      dropping = 1'b0;
      frames   = 0;
    end else if (v) begin
      if (dropping) begin
        if (l) dropping = 1'b0;
      end else if (exp_q.size() == 0 && part_q.size() == DEPTH) begin
        exp_ovf = 1'b1;
        part_q.delete();
        dropping = !l;
      end else if (l && u) begin
        exp_bad = 1'b1;
        part_q.delete();
      end else begin
        part_q.push_back({l, d});
        if (l) begin
          foreach (part_q[i]) exp_q.push_back(part_q[i]);
          part_q.delete();
          frames++;
        end
      end
    end
    @(posedge aclk);
    if (rst) chk_en = 1'b1;
  endtask

  task automatic send_frame(input int len, input int first, input bit bad, input int rmode,
                            input bit gaps_en);
    logic [7:0] d;
    for (int i = 0; i < len; i++) begin
      if (gaps_en && $urandom_range(0, 3) == 0)
        step(1'b0, 8'($urandom), 1'b0, 1'b0, pick_rdy(rmode), 1'b0);
      d = (first < 0) ? 8'($urandom) : 8'(first + i);
      step(1'b1, d, i == len - 1, bad && (i == len - 1), pick_rdy(rmode), 1'b0);
    end
  endtask

  task automatic drain(input int rmode);
    for (int n = 0; n < 400 && exp_q.size() > 0; n++)
      step(1'b0, 8'h00, 1'b0, 1'b0, pick_rdy(rmode), 1'b0);
    for (int n = 0; n < 4; n++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    check("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    int len;
    bit bad;
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    s_axis.tlast  = 1'b0;
    s_axis.tuser  = 1'b0;
    m_axis.tready = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

    send_frame(10, 'h01, 1'b0, 1, 1'b0);
    drain(1);

    bad_seen = 0;
    send_frame(5, 'h30, 1'b1, 1, 1'b0);
    drain(1);
    check("bad_pulses", bad_seen, 1);

    ovf_seen = 0;
    send_frame(70, 'h40, 1'b0, 0, 1'b0);
    for (int n = 0; n < 3; n++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ovf_pulses", ovf_seen, 1);
    send_frame(8, 'hA0, 1'b0, 0, 1'b0);
    drain(1);
    check("ovf_pulses_after", ovf_seen, 1);

    gap_mon = 1'b1;
    started = 1'b0;
    gaps    = 0;
    for (int f = 0; f < 3; f++) send_frame(20, f * 20 + 1, 1'b0, 1, 1'b0);
    drain(1);
    gap_mon = 1'b0;
    check("gaps", gaps, 0);

    send_frame(16, 'h60, 1'b0, 2, 1'b0);
    drain(2);

    send_frame(3, 'h70, 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h90 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'hEF, 1'b1, 1'b0, 1'b0, 1'b1);
    send_frame(6, 'hB0, 1'b0, 1, 1'b0);
    drain(1);

    for (int f = 0; f < 60; f++) begin
      len = $urandom_range(1, 16);
      bad = ($urandom_range(0, 3) == 0);
      for (int n = 0; n < 500 && exp_q.size() + len >= DEPTH; n++)
        step(1'b0, 8'h00, 1'b0, 1'b0, pick_rdy(3), 1'b0);
      send_frame(len, -1, bad, 3, 1'b1);
    end
    drain(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/eth_frame_fifo.md
ETH_FRAME_FIFO -- requirements
Module: eth_frame_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8: AXI-Stream data width in bits, legal 8/16/32/64.
REQ-002 Parameter DEPTH, default 4096: storage depth in words, power of two, 16..65536.
REQ-003 Parameter DROP_BAD_FRAMES, default 1: 1 discards frames ending with tuser=1; 0 forwards them.
REQ-004 aclk  in  1  sole clock; all logic rising-edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 s_axis_tdata  in  DATA_WIDTH  write-side data.
REQ-007 s_axis_tvalid  in  1  write-side valid.
REQ-008 s_axis_tlast  in  1  write-side end of frame.
REQ-009 s_axis_tuser  in  1  bad-frame flag, sampled only on the tlast beat.
REQ-010 s_axis_tready  out  1  constant 1 outside reset; full is handled by dropping, never by backpressure.
REQ-011 m_axis_tdata  out  DATA_WIDTH  read-side data.
REQ-012 m_axis_tvalid  out  1  read-side valid.
REQ-013 m_axis_tlast  out  1  read-side end of frame.
REQ-014 m_axis_tready  in  1  read-side ready.
REQ-015 fifo_overflow  out  1  one-cycle pulse per frame dropped for lack of space.
REQ-016 fifo_bad_frame  out  1  one-cycle pulse per frame dropped by tuser (DROP_BAD_FRAMES=1 only).
REQ-017 fifo_status  out  4  occupancy: floor((wr_ptr-rd_ptr)*16/DEPTH), saturated at 15.
REQ-018 frame_count  out  $clog2(DEPTH)+1  committed frames not yet fully read.

Function
REQ-019 Store-and-forward: words stored as {tlast, tdata}; read side never exposes a word beyond the commit pointer.
REQ-020 Pointers wr_ptr (speculative), wr_commit, rd_ptr: $clog2(DEPTH)+1 bits, wrap modulo 2*DEPTH; full when wr_ptr-rd_ptr == DEPTH.
REQ-021 Write FSM states IDLE, WRITE, DROP; IDLE->WRITE on accepted non-tlast beat; WRITE/IDLE->IDLE on accepted tlast beat that commits or discards.
REQ-022 Good tlast beat (tuser=0, or DROP_BAD_FRAMES=0) stored: wr_commit <= wr_ptr+1, frame_count +1, next cycle.
REQ-023 Bad tlast beat with DROP_BAD_FRAMES=1: beat not stored, wr_ptr <= wr_commit, fifo_bad_frame pulses next cycle.
REQ-024 Beat arriving while full (any state but DROP): wr_ptr <= wr_commit, fifo_overflow pulses next cycle; if not tlast go DROP, else IDLE.
REQ-025 DROP: discard all beats up to and including tlast, then IDLE; no further pulses for that frame.
REQ-026 Read side: 1-cycle registered RAM read plus one output register; fetch whenever rd_ptr != wr_commit and output stage empty or being consumed.
REQ-027 First word of a frame valid at m_axis no later than 3 cycles after its committing tlast beat; sustained 1 word/cycle with tready high.
REQ-028 m_axis_tdata/tlast held stable while tvalid=1 and tready=0.
REQ-029 frame_count decrements on m_axis tlast handshake; simultaneous commit and handshake leave it unchanged.
REQ-030 Simultaneous write at full and read handshake: full evaluated on registered pointers before the read; beat dropped.

Reset
REQ-031 On reset: pointers 0, FSM IDLE, output stage empty; m_axis_tvalid, m_axis_tlast, fifo_overflow, fifo_bad_frame 0; m_axis_tdata 0; fifo_status 0; frame_count 0; s_axis_tready 0.
REQ-032 Reset mid-frame discards all stored and partial frames; beats during reset ignored; a frame whose start was in reset is written from its first post-reset beat.

Structure
REQ-033 Package eth_fifo_pkg holds write-FSM state enum, status width constant (4) and pointer-width function.
REQ-034 Sub-module eth_fifo_ram: simple dual-port, one write port, one registered read port, width DATA_WIDTH+1, depth DEPTH.

Verification (DATA_WIDTH=8, DEPTH=64)
REQ-035 Frame 0x01..0x0A, tuser=0, tready=1 -> same 10 bytes out, tlast on 0x0A, frame_count 1 then 0.
REQ-036 Frame of 5 bytes with tuser=1 on tlast -> no m_axis output, fifo_bad_frame single pulse, fifo_status returns 0.
REQ-037 tready=0, write 70-byte frame -> fifo_overflow one pulse at byte 65, no output; next 8-byte frame passes intact.
REQ-038 Three back-to-back 20-byte frames, tready=1 -> 60 bytes in order, no gaps after first word, three tlasts.
REQ-039 tready toggled 1/0 each cycle over a 16-byte frame -> data unchanged while stalled, frame complete.
REQ-040 Reset asserted after byte 4 of a 10-byte frame -> outputs per REQ-031; following 6-byte frame received correctly.
